// File: rtl/rr_mux_n.sv
// rr_mux_n: registered N-to-1 datapath multiplexer with per-channel
// valid/ready handshake. A one-deep output register holds the selected
// word. The channel is chosen either by round-robin arbitration (mode = 0)
// or by an index from the control unit (mode = 1). in_ready is
// combinational from out_ready, so upstream sources must not make in_valid
// depend on in_ready.
module rr_mux_n #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  // Reset value of last_grant: the highest channel, so that the round-robin
  // search after reset starts at channel 0.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             out_valid_q,  out_valid_d;
  logic [SEL_W-1:0] out_sel_q,    out_sel_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic             load_en;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;

  // The output register can accept a word when empty or draining this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Pick the granted channel: round-robin from last_grant+1, or fixed select.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (mode) begin
      // An out-of-range sel never matches any channel, so it never grants.
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = SEL_W'(i);
        end
      end
    end else begin
      // First pass: channels above last_grant, in ascending order.
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_valid && in_valid[i] && (i > int'(last_grant_q))) begin
          grant_valid = 1'b1;
          grant       = SEL_W'(i);
        end
      end
      // Second pass wraps around: channels 0 up to last_grant.
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_valid && in_valid[i] && (i <= int'(last_grant_q))) begin
          grant_valid = 1'b1;
          grant       = SEL_W'(i);
        end
      end
    end
  end

  // Route the granted channel's data and raise its ready when it can load.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load_en && grant_valid;
      end
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (grant_valid) begin
        out_data_d   = grant_data;
        out_sel_d    = grant;
        out_valid_d  = 1'b1;
        last_grant_d = grant;
      end else begin
        // Drained or already empty with nothing to take: go empty, keep data.
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sel_q    <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: a 4x32 instance for arbitration, fixed
// select, backpressure and reset, plus a 3x8 instance for the
// non-power-of-2 select range.
module tb_rr_mux_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-channel, 32-bit instance
  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid;
  logic [3:0]   a_in_ready;
  logic         a_mode;
  logic [1:0]   a_sel;
  logic [31:0]  a_out_data;
  logic         a_out_valid;
  logic         a_out_ready;
  logic [1:0]   a_out_sel;

  // 3-channel, 8-bit instance
  logic [23:0]  b_in_data;
  logic [2:0]   b_in_valid;
  logic [2:0]   b_in_ready;
  logic         b_mode;
  logic [1:0]   b_sel;
  logic [7:0]   b_out_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [1:0]   b_out_sel;

  rr_mux_n #(.WIDTH(32), .NUM_IN(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mode(a_mode), .sel(a_sel),
    .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_sel(a_out_sel)
  );

  rr_mux_n #(.WIDTH(8), .NUM_IN(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode(b_mode), .sel(b_sel),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sel(b_out_sel)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Expected-output check for instance A.
  task automatic chk_a(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".sel"},   32'(a_out_sel),   32'(s));
    chk({tag, ".data"},  a_out_data,       d);
  endtask

  initial begin
    logic [1:0] seq [4];
    seq = '{2'd1, 2'd3, 2'd1, 2'd3};

    rst_n       = 1'b0;
    a_in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    a_in_valid  = 4'b0000;
    a_mode      = 1'b0;
    a_sel       = 2'd0;
    a_out_ready = 1'b1;
    b_in_data   = {8'h5C, 8'h22, 8'h11};
    b_in_valid  = 3'b000;
    b_mode      = 1'b1;
    b_sel       = 2'd3;
    b_out_ready = 1'b1;

    // Reset state
    cyc(); cyc();
    chk_a("rst", 1'b0, 2'd0, 32'h0);
    chk("rst.in_ready", 32'(a_in_ready), 32'h0);
    chk("rst.b_valid", 32'(b_out_valid), 32'h0);

    // Round robin, all channels valid: 0,1,2,3,0 with no bubbles
    rst_n      = 1'b1;
    a_in_valid = 4'b1111;
    #1 chk("rr.first_ready", 32'(a_in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_a($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 32'hA0 + 32'(k % 4));
    end

    // Fixed select on channel 2
    a_mode = 1'b1;
    a_sel  = 2'd2;
    #1 chk("fix.ready", 32'(a_in_ready), 32'h4);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_a($sformatf("fix%0d", k), 1'b1, 2'd2, 32'hA2);
      chk($sformatf("fix%0d.ready", k), 32'(a_in_ready), 32'h4);
    end
    a_in_valid = 4'b1011;
    #1 chk("fix.drop_ready", 32'(a_in_ready), 32'h0);
    cyc();
    chk_a("fix.empty", 1'b0, 2'd2, 32'hA2);

    // Backpressure: load channel 3 with out_ready low, then hold
    a_mode      = 1'b0;
    a_in_valid  = 4'b1111;
    a_out_ready = 1'b0;
    #1 chk("bp.load_ready", 32'(a_in_ready), 32'h8);
    cyc();
    chk_a("bp.loaded", 1'b1, 2'd3, 32'hA3);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_a($sformatf("bp.hold%0d", k), 1'b1, 2'd3, 32'hA3);
      chk($sformatf("bp.hold%0d.ready", k), 32'(a_in_ready), 32'h0);
    end
    a_out_ready = 1'b1;
    #1 chk("bp.release_ready", 32'(a_in_ready), 32'h1);
    cyc();
    chk_a("bp.reload", 1'b1, 2'd0, 32'hA0);

    // Sparse round robin: park last_grant on 3, then only channels 1 and 3
    a_in_valid = 4'b1000;
    #1 chk("sp.park_ready", 32'(a_in_ready), 32'h8);
    cyc();
    chk_a("sp.park", 1'b1, 2'd3, 32'hA3);
    a_in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("sp%0d.ready", k), 32'(a_in_ready), 32'h1 << seq[k]);
      cyc();
      chk_a($sformatf("sp%0d", k), 1'b1, seq[k], 32'hA0 + 32'(seq[k]));
    end

    // Asynchronous reset between edges while a word is held
    #2 rst_n = 1'b0;
    #1 chk_a("arst", 1'b0, 2'd0, 32'h0);
    cyc();
    rst_n      = 1'b1;
    a_in_valid = 4'b1111;
    #1 chk("arst.first_ready", 32'(a_in_ready), 32'h1);
    cyc();
    chk_a("arst.first", 1'b1, 2'd0, 32'hA0);
    a_in_valid = 4'b0000;

    // 3-channel, 8-bit: out-of-range select never grants
    b_in_valid = 3'b111;
    #1 chk("b.sel3_ready", 32'(b_in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("b.sel3_%0d.valid", k), 32'(b_out_valid), 32'h0);
      chk($sformatf("b.sel3_%0d.ready", k), 32'(b_in_ready), 32'h0);
    end
    b_sel = 2'd2;
    #1 chk("b.sel2_ready", 32'(b_in_ready), 32'h4);
    cyc();
    chk("b.sel2.valid", 32'(b_out_valid), 32'h1);
    chk("b.sel2.data",  32'(b_out_data),  32'h5C);
    chk("b.sel2.sel",   32'(b_out_sel),   32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
- Parametrised, registered N-to-1 datapath multiplexer with per-channel valid/ready handshake. Generalises the 4:1 32-bit select mux in width and channel count.
- Adds a one-deep output register and two selection modes: round-robin arbitration, or fixed select driven by the control unit.
- Used where several processor sources (ALU, memory read, PC+4, immediate) compete for one writeback/bus path.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 4, number of input channels; must be >= 2.
- SEL_W, derived as clog2(NUM_IN), width of the select and index fields. Local parameter, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel data valid.
- in_ready  output  NUM_IN  per-channel accept; combinational.
- mode  input  1  0 = round-robin arbitration, 1 = fixed select.
- sel  input  SEL_W  channel index used when mode = 1.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accept.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, out_sel = 0, internal last_grant = NUM_IN-1. With this value, channel 0 has top round-robin priority after reset. in_ready is all zero while out_valid = 0 and no input is valid.
- load_en = !out_valid || out_ready. The output register can take a new word when it is empty or is being drained in the same cycle.
- Grant, mode = 0: the first i with in_valid[i] = 1, searching upward from last_grant+1 modulo NUM_IN.
- Grant, mode = 1: grant = sel if in_valid[sel] = 1; otherwise no grant. If sel >= NUM_IN (non-power-of-2 NUM_IN), there is never a grant.
- in_ready[i] = load_en && grant_valid && (grant == i). At most one bit is set per cycle.
- Transfer cycle (any in_valid[i] && in_ready[i]):
  - next edge: out_data <= channel i data, out_sel <= i, out_valid <= 1, last_grant <= i.
  - last_grant updates in both modes.
- load_en with no grant: out_valid <= 0. out_data and out_sel hold their old values.
- !load_en (out_valid = 1, out_ready = 0): out_data, out_sel and out_valid hold. All in_ready = 0.
- Latency: input transfer to out_valid is 1 cycle. Sustained throughput is 1 word per cycle when out_ready is held high.
- Simultaneous drain and load: the old word is consumed and the new word is captured on the same edge. out_valid stays 1 with no bubble.
- mode/sel changes: take effect in the arbitration of the same cycle. A word already in the output register is unaffected.
- Round-robin wrap-around: after grant to NUM_IN-1, search restarts at channel 0.
- Fairness: with all channels continuously valid, each channel is granted once every NUM_IN transfers.
- Reset asserted mid-transfer: the pending word is discarded. out_valid drops immediately (asynchronous), with no partial update.
- Combinational path: out_ready -> in_ready. Upstream must not make in_valid depend on in_ready.
- Sources must hold in_data/in_valid stable until accepted; the block does not check this.

Test Plan:
- Reset then round robin: NUM_IN=4, mode=0, all in_valid=1, data = 0xA0+i, out_ready=1. Required: out_sel sequence 0,1,2,3,0; out_data 0xA0..0xA3,0xA0; out_valid high from cycle 2 with no bubbles.
- Fixed select: mode=1, sel=2, all valid. Required: only in_ready[2] pulses, out_data = 0xA2 every cycle. Then drop in_valid[2]: out_valid falls after one cycle while channels 0, 1 and 3 remain valid.
- Backpressure: out_ready=0 with a word loaded. Required: out_data, out_sel and out_valid hold for 5 cycles with in_ready=0. Raising out_ready drains and reloads on the same edge.
- Sparse round robin: only channels 1 and 3 valid, last_grant=3. Required: grants 1,3,1,3; channels 0 and 2 are never granted.
- Asynchronous reset mid-stream: pull rst_n low between clock edges while out_valid=1. Required: out_valid=0 and out_data=0 immediately. After release, the first grant goes to channel 0.
- Width/count sweep: WIDTH=8 with NUM_IN=3, mode=1, sel=3. Required: no grant, out_valid stays 0. With sel=2, 0x5C on channel 2 appears as out_data=0x5C with out_sel=2.
